// File: rtl/char_rx_fifo.sv
// Terminal receive FIFO behind a word-addressed register slave; reads answer one cycle later.
// The optional interrupt is built only when CHAR_RX_FIFO_IRQ_EN is defined.
module char_rx_fifo #(
   parameter int DEPTH_LOG2 = 4,
   parameter int IRQ_THRESH = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  char,
   input  logic        strobe,
   input  logic        sel,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        irq
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;

   localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   logic        strobe_q;
   ptr_t        rd_ptr_q, rd_ptr_d;
   ptr_t        wr_ptr_q, wr_ptr_d;
   cnt_t        count_q, count_d;
   logic        ovf_q, ovf_d;
   logic        irq_en_q, irq_en_d;
   logic        irq_q, irq_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rvalid_q;
   logic [7:0]  mem_q [DEPTH];

   logic        rd_acc, wr_acc, ctrl_wr;
   logic [1:0]  reg_sel;
   logic        empty, full;
   logic        push_evt, flush, clr_ovf, pop, push, drop;
   logic [31:0] cnt_wide, status_word;
   logic        unused_bits;

   assign rd_acc   = sel & ~we;
   assign wr_acc   = sel & we;
   assign reg_sel  = addr[3:2];
   assign ctrl_wr  = wr_acc & (reg_sel == REG_CTRL);
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign push_evt = strobe & ~strobe_q;
   assign flush    = ctrl_wr & wdata[0];
   assign clr_ovf  = ctrl_wr & wdata[1];
   assign pop      = rd_acc & (reg_sel == REG_DATA) & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the char.
   assign push     = push_evt & ~flush & (~full | pop);
   assign drop     = push_evt & ~flush & full & ~pop;

   assign cnt_wide    = 32'(count_q);
   assign status_word = {16'b0, cnt_wide[7:0], 5'b0, ovf_q, full, ~empty};

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      rdata_d  = rdata_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end

      // Set after clear so a fresh overflow is never lost.
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;

      if (rd_acc) begin
         case (reg_sel)
            REG_DATA:   rdata_d = empty ? 32'b0 : {24'b0, mem_q[rd_ptr_q]};
            REG_STATUS: rdata_d = status_word;
            REG_CTRL:   rdata_d = {29'b0, irq_en_q, 2'b0};
            default:    rdata_d = 32'b0;
         endcase
      end
   end

`ifdef CHAR_RX_FIFO_IRQ_EN
   localparam cnt_t IRQ_CNT = cnt_t'(IRQ_THRESH);

   always_comb begin
      irq_en_d = irq_en_q;
      if (ctrl_wr) irq_en_d = wdata[2];
      irq_d = irq_en_d & ((count_d >= IRQ_CNT) | ovf_d);
   end

   assign unused_bits = ^{wdata[31:3], addr[1:0]};
`else
   always_comb begin
      irq_en_d = 1'b0;
      irq_d    = 1'b0;
   end

   assign unused_bits = (^{wdata[31:2], addr[1:0]}) ^ (IRQ_THRESH != 0);
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         strobe_q <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
         rdata_q  <= 32'b0;
         rvalid_q <= 1'b0;
      end else begin
         strobe_q <= strobe;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rd_acc;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= char;
   end

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign irq    = irq_q;

endmodule

// File: tb/tb_char_rx_fifo.sv
// Bench for char_rx_fifo: directed scenarios plus a random run against a queue-based model.
module tb_char_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int THRESH = 2;
`ifdef CHAR_RX_FIFO_IRQ_EN
   localparam bit IRQ_BUILD = 1'b1;
`else
   localparam bit IRQ_BUILD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn, strobe, sel, we, rvalid, irq;
   logic [7:0]  ch;
   logic [3:0]  addr;
   logic [31:0] wdata, rdata;

   always #5 clk = ~clk;

   char_rx_fifo #(.DEPTH_LOG2(4), .IRQ_THRESH(THRESH)) dut (
      .clk(clk), .resetn(resetn), .char(ch), .strobe(strobe), .sel(sel), .we(we),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .irq(irq)
   );

   int n_checks = 0;
   int n_fail   = 0;

   byte unsigned mq[$];
   bit           m_ovf, m_irq_en, m_strobe_prev;
   logic [31:0]  exp_rdata;
   bit           exp_rvalid, exp_irq;

   task automatic model_reset();
      mq.delete();
      m_ovf = 0; m_irq_en = 0; m_strobe_prev = 0;
      exp_rdata = 32'h0; exp_rvalid = 0; exp_irq = 0;
   endtask

   function automatic logic [31:0] model_read(input logic [1:0] r);
      case (r)
         2'd0:    return (mq.size() != 0) ? {24'h0, mq[0]} : 32'h0;
         2'd1:    return {16'h0, 8'(mq.size()), 5'b0, m_ovf, (mq.size() == DEPTH), (mq.size() != 0)};
         2'd2:    return {29'h0, m_irq_en, 2'b0};
         default: return 32'h0;
      endcase
   endfunction

   // Drive one cycle of inputs, advance the model, then step past the clock edge.
   task automatic cyc(input bit s, input logic [7:0] c, input bit sl, input bit w,
                      input logic [3:0] a, input logic [31:0] wd);
      bit rd, wr, push_evt, fl;
      strobe = s; ch = c; sel = sl; we = w; addr = a; wdata = wd;
      rd = sl & !w;
      wr = sl & w;
      exp_rvalid = rd;
      if (rd) exp_rdata = model_read(a[3:2]);
      push_evt = s & !m_strobe_prev;
      m_strobe_prev = s;
      fl = wr && a[3:2] == 2'd2 && wd[0];
      if (fl) mq.delete();
      if (wr && a[3:2] == 2'd2 && wd[1]) m_ovf = 0;
      if (wr && a[3:2] == 2'd2) m_irq_en = IRQ_BUILD & wd[2];
      if (rd && a[3:2] == 2'd0 && mq.size() != 0) void'(mq.pop_front());
      if (push_evt && !fl) begin
         if (mq.size() < DEPTH) mq.push_back(c);
         else m_ovf = 1;
      end
      exp_irq = m_irq_en && (mq.size() >= THRESH || m_ovf);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(0, 8'h00, 0, 0, 4'h0, 32'h0);
   endtask

   task automatic push_char(input logic [7:0] c);
      cyc(1, c, 0, 0, 4'h0, 32'h0);
      idle();
   endtask

   task automatic rd_reg(input logic [1:0] r);
      logic [1:0] lo;
      lo = 2'($urandom_range(0, 3));
      cyc(0, 8'h00, 1, 0, {r, lo}, 32'h0);
   endtask

   task automatic wr_reg(input logic [1:0] r, input logic [31:0] d);
      cyc(0, 8'h00, 1, 1, {r, 2'b00}, d);
   endtask

   task automatic do_reset();
      resetn = 0; strobe = 0; ch = 0; sel = 0; we = 0; addr = 0; wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) resetn = 1;
      @(posedge clk);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin n_fail++; $display("FAIL reset_status: got %h/%b expected 00000000/1", rdata, rvalid); end
      rd_reg(2'd0);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data_empty: got %h expected 00000000", rdata); end
      idle();
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b expected 0", rvalid); end
   endtask

   task automatic test_order();
      push_char(8'h41); push_char(8'h42); push_char(8'h43);
      for (int i = 0; i < 3; i++) begin
         rd_reg(2'd0);
         n_checks++; if (rdata !== 32'h41 + i) begin n_fail++; $display("FAIL order_data%0d: got %h expected %h", i, rdata, 32'h41 + i); end
      end
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL order_status: got %h expected 00000000", rdata); end
   endtask

   task automatic test_held_strobe();
      for (int i = 0; i < 5; i++) cyc(1, 8'h55, 0, 0, 4'h0, 32'h0);
      idle();
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0000_0101) begin n_fail++; $display("FAIL held_status: got %h expected 00000101", rdata); end
      rd_reg(2'd0);
      n_checks++; if (rdata !== 32'h55) begin n_fail++; $display("FAIL held_data: got %h expected 00000055", rdata); end
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL held_empty: got %h expected 00000000", rdata); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i <= 16; i++) push_char(8'(i));
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0000_1007) begin n_fail++; $display("FAIL ovf_status: got %h expected 00001007", rdata); end
      for (int i = 0; i < 16; i++) begin
         rd_reg(2'd0);
         n_checks++; if (rdata !== 32'(i)) begin n_fail++; $display("FAIL ovf_data%0d: got %h expected %h", i, rdata, 32'(i)); end
      end
      rd_reg(2'd0);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL ovf_lost: got %h expected 00000000", rdata); end
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h4) begin n_fail++; $display("FAIL ovf_sticky: got %h expected 00000004", rdata); end
      wr_reg(2'd2, 32'h2);
      n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL write_rvalid: got %b expected 0", rvalid); end
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL ovf_clear: got %h expected 00000000", rdata); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 16; i++) push_char(8'h20 + 8'(i));
      cyc(1, 8'h7E, 1, 0, 4'h0, 32'h0);
      n_checks++; if (rdata !== 32'h20) begin n_fail++; $display("FAIL fpp_oldest: got %h expected 00000020", rdata); end
      idle();
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0000_1003) begin n_fail++; $display("FAIL fpp_status: got %h expected 00001003", rdata); end
      for (int i = 0; i < 16; i++) begin
         rd_reg(2'd0);
         n_checks++; if (rdata !== ((i == 15) ? 32'h7E : 32'h21 + i)) begin n_fail++; $display("FAIL fpp_data%0d: got %h expected %h", i, rdata, (i == 15) ? 32'h7E : 32'h21 + i); end
      end
   endtask

   task automatic test_simultaneous();
      cyc(1, 8'h33, 1, 0, 4'h0, 32'h0);
      n_checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin n_fail++; $display("FAIL pushpop_empty: got %h/%b expected 00000000/1", rdata, rvalid); end
      idle();
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0000_0101) begin n_fail++; $display("FAIL pushpop_count: got %h expected 00000101", rdata); end
      rd_reg(2'd0);
      n_checks++; if (rdata !== 32'h33) begin n_fail++; $display("FAIL pushpop_data: got %h expected 00000033", rdata); end
      push_char(8'h61);
      cyc(1, 8'h62, 1, 1, 4'h8, 32'h1);
      idle();
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL flush_push: got %h expected 00000000", rdata); end
      for (int i = 0; i < 16; i++) push_char(8'(i));
      cyc(1, 8'h99, 1, 1, 4'h8, 32'h2);
      idle();
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0000_1007) begin n_fail++; $display("FAIL clr_vs_set: got %h expected 00001007", rdata); end
      wr_reg(2'd2, 32'h3);
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL flush_clear: got %h expected 00000000", rdata); end
      rd_reg(2'd3);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reg3_read: got %h expected 00000000", rdata); end
   endtask

   task automatic test_irq();
      wr_reg(2'd2, 32'h4);
      rd_reg(2'd2);
      n_checks++; if (rdata !== (IRQ_BUILD ? 32'h4 : 32'h0)) begin n_fail++; $display("FAIL irq_ctrl: got %h expected %h", rdata, IRQ_BUILD ? 32'h4 : 32'h0); end
      push_char(8'h01);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_one: got %b expected 0", irq); end
      cyc(1, 8'h02, 0, 0, 4'h0, 32'h0);
      n_checks++; if (irq !== IRQ_BUILD) begin n_fail++; $display("FAIL irq_two: got %b expected %b", irq, IRQ_BUILD); end
      idle();
      rd_reg(2'd0);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_drop: got %b expected 0", irq); end
      wr_reg(2'd2, 32'h1);
   endtask

   task automatic test_random();
      bit s, sl, w;
      logic [31:0] wd;
      for (int n = 0; n < 3000; n++) begin
         s  = ($urandom_range(0, 2) == 0);
         sl = ($urandom_range(0, 1) == 1);
         w  = ($urandom_range(0, 4) == 0);
         wd = $urandom;
         if ($urandom_range(0, 19) != 0) wd[0] = 1'b0;
         cyc(s, 8'($urandom), sl, w, 4'($urandom), wd);
         n_checks++; if (rvalid !== exp_rvalid) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got %b expected %b", n, rvalid, exp_rvalid); end
         n_checks++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h expected %h", n, rdata, exp_rdata); end
         n_checks++; if (irq !== exp_irq) begin n_fail++; $display("FAIL rnd_irq@%0d: got %b expected %b", n, irq, exp_irq); end
      end
   endtask

   task automatic test_reset_mid();
      idle();
      push_char(8'h11);
      rd_reg(2'd1);
      n_checks++; if (rvalid !== 1'b1 || rdata !== exp_rdata) begin n_fail++; $display("FAIL mid_pre: got %h/%b expected %h/1", rdata, rvalid, exp_rdata); end
      resetn = 0;
      #1;
      n_checks++; if (rvalid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %h/%b/%b expected 00000000/0/0", rdata, rvalid, irq); end
      @(negedge clk) resetn = 1;
      @(posedge clk);
      #1;
      model_reset();
      rd_reg(2'd1);
      n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL mid_status: got %h expected 00000000", rdata); end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_order();
      test_held_strobe();
      test_overflow();
      test_full_push_pop();
      test_simultaneous();
      test_irq();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
